// File: rtl/scan_peak_detect_if.sv
// rtl/scan_peak_detect_if.sv - scan/monitor inputs, controls and published results of the scan peak detector
interface scan_peak_detect_if #(
  parameter int R  = 14,
  parameter int CW = 32
);
  logic signed [R-1:0] scan_val;
  logic signed [R-1:0] sig_in;
  logic                trig_start;
  logic                arm;
  logic                abort;
  logic                find_min;
  logic                continuous;
  logic signed [R-1:0] peak_val;
  logic signed [R-1:0] peak_pos;
  logic [CW-1:0]       period_ticks;
  logic [15:0]         sweep_cnt;
  logic                valid;
  logic                busy;

  modport master (
    output scan_val, sig_in, trig_start, arm, abort, find_min, continuous,
    input  peak_val, peak_pos, period_ticks, sweep_cnt, valid, busy
  );

  modport slave (
    input  scan_val, sig_in, trig_start, arm, abort, find_min, continuous,
    output peak_val, peak_pos, period_ticks, sweep_cnt, valid, busy
  );
endinterface

// File: rtl/scan_peak_detect.sv
// rtl/scan_peak_detect.sv - per-scan-period extremum tracker of a monitored signal
// SWEEP_INIT sets the sweep counter value loaded at reset (0 in normal use).
module scan_peak_detect #(
  parameter int          R          = 14,
  parameter int          CW         = 32,
  parameter logic [15:0] SWEEP_INIT = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  scan_peak_detect_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    ACQ        = 2'd2
  } state_t;

  state_t              state_q;

  logic signed [R-1:0] scan_q;
  logic signed [R-1:0] sig_q;
  logic                trig_q;

  logic signed [R-1:0] cur_val_q;
  logic signed [R-1:0] cur_pos_q;
  logic [CW-1:0]       tick_q;
  logic                mode_q;

  logic signed [R-1:0] peak_val_q;
  logic signed [R-1:0] peak_pos_q;
  logic [CW-1:0]       period_ticks_q;
  logic [15:0]         sweep_cnt_q;
  logic                valid_q;
  logic                busy_q;

  logic                better_d;
  logic [CW-1:0]       tick_d;
  logic                restart_d;

  // Strict comparison so a tie keeps the first occurrence of the extremum.
  always_comb begin
    better_d = 1'b0;
    if (mode_q) begin
      better_d = (sig_q < cur_val_q);
    end else begin
      better_d = (sig_q > cur_val_q);
    end
  end

  assign tick_d    = (&tick_q) ? tick_q : (tick_q + CW'(1));
  assign restart_d = bus.continuous && bus.arm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      scan_q         <= '0;
      sig_q          <= '0;
      trig_q         <= 1'b0;
      cur_val_q      <= '0;
      cur_pos_q      <= '0;
      tick_q         <= '0;
      mode_q         <= 1'b0;
      peak_val_q     <= '0;
      peak_pos_q     <= '0;
      period_ticks_q <= '0;
      sweep_cnt_q    <= SWEEP_INIT;
      valid_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      scan_q  <= bus.scan_val;
      sig_q   <= bus.sig_in;
      trig_q  <= bus.trig_start;
      valid_q <= 1'b0;

      if (bus.abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.arm) begin
              state_q <= WAIT_START;
              busy_q  <= 1'b1;
            end
          end

          WAIT_START: begin
            if (!bus.arm) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (trig_q) begin
              cur_val_q <= sig_q;
              cur_pos_q <= scan_q;
              tick_q    <= CW'(1);
              mode_q    <= bus.find_min;
              state_q   <= ACQ;
            end
          end

          ACQ: begin
            if (trig_q) begin
              // The trigger sample closes this period and opens the next one.
              peak_val_q     <= cur_val_q;
              peak_pos_q     <= cur_pos_q;
              period_ticks_q <= tick_q;
              sweep_cnt_q    <= sweep_cnt_q + 16'd1;
              valid_q        <= 1'b1;
              if (restart_d) begin
                cur_val_q <= sig_q;
                cur_pos_q <= scan_q;
                tick_q    <= CW'(1);
                mode_q    <= bus.find_min;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tick_q <= tick_d;
              if (better_d) begin
                cur_val_q <= sig_q;
                cur_pos_q <= scan_q;
              end
            end
          end

          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.peak_val     = peak_val_q;
  assign bus.peak_pos     = peak_pos_q;
  assign bus.period_ticks = period_ticks_q;
  assign bus.sweep_cnt    = sweep_cnt_q;
  assign bus.valid        = valid_q;
  assign bus.busy         = busy_q;

endmodule

// File: doc/scan_peak_detect.md
Name: scan_peak_detect

Overview:
- Sits directly downstream of the triangular scan generator.
- Consumes the scan ramp value (outA) and its low-limit trigger, plus one monitored ADC/demodulated signal.
- Over each full scan period (low-limit trigger to next low-limit trigger), finds the extremum (max or min) of the monitored signal and the scan value where it occurred.
- Publishes the results to the register bank, for software lock-point selection and relock centring.

Parameters:
- R, 14, width of scan value, monitored signal and peak outputs (signed).
- CW, 32, width of the period tick counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- scan_val  in  R  signed scan ramp value (outA of scan generator).
- sig_in  in  R  signed monitored signal, sample-aligned with scan_val.
- trig_start  in  1  one-cycle pulse at scan low limit (trigger_low).
- arm  in  1  level; enables acquisition.
- abort  in  1  level/pulse; forces IDLE, no publish.
- find_min  in  1  0 = track maximum, 1 = track minimum; sampled only at a sweep start.
- continuous  in  1  1 = re-acquire every period; 0 = single shot.
- peak_val  out  R  signed extremum of sig_in over the last completed period.
- peak_pos  out  R  signed scan_val at the extremum.
- period_ticks  out  CW  clock cycles in the last completed period.
- sweep_cnt  out  16  completed periods since reset; wraps.
- valid  out  1  one-cycle pulse when outputs update.
- busy  out  1  high in WAIT_START or ACQ.

Behaviour:
- Reset (rst=0, async): FSM=IDLE. Outputs cleared: peak_val=0, peak_pos=0, period_ticks=0, sweep_cnt=0, valid=0, busy=0. Internal trackers cleared.
- Input stage: scan_val, sig_in and trig_start are registered once together. All decisions use the registered copies.
- Input-to-valid latency: 2 cycles from the trig_start that closes a period (register stage + publish).
- IDLE: busy=0. If arm=1 and abort=0, go to WAIT_START next cycle.
- WAIT_START: busy=1. On a registered trig_start:
  - load cur_val=sig_in and cur_pos=scan_val;
  - set tick counter to 1;
  - latch mode=find_min;
  - go to ACQ.
- WAIT_START exit without a trigger: arm=0 returns to IDLE.
- ACQ, every cycle without trig_start:
  - tick counter increments, saturating at 2^CW-1;
  - max mode: if sig_in > cur_val (strict), load sig_in and scan_val;
  - min mode: if sig_in < cur_val (strict), load sig_in and scan_val;
  - ties keep the first occurrence.
- ACQ, on trig_start (period closes), the closing sample is NOT part of the finished period:
  - peak_val<=cur_val, peak_pos<=cur_pos, period_ticks<=tick counter, sweep_cnt<=sweep_cnt+1;
  - valid=1 for exactly that one cycle.
  - If continuous=1 and arm=1: restart trackers from the closing sample (as in WAIT_START), re-latch find_min, stay in ACQ. No sample is dropped between periods.
  - Otherwise go to IDLE; busy falls the same cycle valid rises.
- arm dropped during ACQ: the current period completes and publishes. Then go to IDLE regardless of continuous.
- abort=1 in any state: IDLE next cycle, no publish, outputs keep their last published values. Abort has priority over a simultaneous trig_start.
- Scan reset mid-period: not visible to this block. The period simply runs until the next trig_start. Software uses period_ticks to reject short or odd periods.
- Arithmetic: signed comparisons only, no sums, no overflow paths. period_ticks saturates and never wraps. sweep_cnt wraps 0xFFFF->0.
- Outputs are registered and stable between valid pulses.

Test Plan:
- Single-shot max: arm=1, continuous=0, scan ramps -100..+100 over 200 cycles, sig_in = 1000 - |scan_val-37|*5 -> one valid; peak_val=1000, peak_pos=37, period_ticks=200, sweep_cnt=1, then IDLE with busy=0.
- Min mode with tie: find_min=1, sig_in=-500 at scan_val=-20 and again at scan_val=+20 -> peak_val=-500, peak_pos=-20 (first occurrence kept).
- Continuous, 3 periods of 150 cycles each, peak location moving 10, 20, 30 -> valid pulses exactly 150 cycles apart; peak_pos=10, 20, 30 in turn; sweep_cnt 1..3; no gap cycles.
- Abort at cycle 80 of a period with a pending max of 900 -> no valid; peak_val keeps its prior value; FSM in IDLE within 1 cycle. An abort asserted in the same cycle as trig_start also yields no publish.
- Async reset asserted mid-ACQ between clock edges -> all outputs 0 immediately. After release with arm=1, the block waits for a fresh trig_start before tracking.
- Saturation and wrap: force a period longer than 2^CW-1 with CW=8 -> period_ticks=255. Preload sweep_cnt=0xFFFF -> the next publish gives 0x0000.
